seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller sharing one BCD-to-7-seg decoder across NUM_DIGITS common-anode digits.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_bcd_decode.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
//   Shared definitions for the 7-segment scan controller: the scan FSM state
//   type, the all-dark segment code and the BCD segment lookup table.
//   Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        ST_DARK = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } seg_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low pattern for decimal digit n.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // True for codes that have a glyph; 10..15 are shown blank.
    function automatic logic is_bcd(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/seg_bcd_decode.sv
// ---------------------------------------------------------------------------
// seg_bcd_decode
//   Combinational BCD to 7-segment decoder, active-low outputs.
//   Codes 10..15 decode to the all-dark pattern.
// Ports
//   i_bcd    in   4   BCD code of the digit being displayed
//   o_seg_n  out  7   active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg_bcd_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        if (is_bcd(i_bcd)) begin
            o_seg_n = SEG_TABLE[i_bcd];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
//   share one BCD decoder. A new digit vector is taken over a valid/ready
//   handshake into a pending buffer and only copied into the displayed
//   (shadow) digits at a frame boundary, so a frame never mixes old and new
//   values. Each digit is lit for DWELL cycles, followed by GAP_CYC all-dark
//   cycles to suppress ghosting.
//
// Build option
//   SEG_SCAN_LZB_EN : when defined, leading zeros are blanked (digit i>0 whose
//                     value and all higher digits are zero keeps its anode
//                     off during its slot). Digit 0 is never blanked.
//
// Ports
//   clk          in   1             clock, rising edge
//   rst          in   1             synchronous active-high reset
//   en           in   1             0 = display dark, scan parked at digit 0
//   load_valid   in   1             load_data valid
//   load_ready   out  1             controller can accept load_data
//   load_data    in   4*NUM_DIGITS  BCD digits, [3:0] = digit 0 (LSD)
//   seg_n        out  7             active-low segments {g,f,e,d,c,b,a}
//   an_n         out  NUM_DIGITS    active-low anodes, an_n[i] = digit i
//   frame_start  out  1             pulse on entry to the digit-0 slot
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int GAP_CYC    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW_W  = (DWELL > 1)      ? $clog2(DWELL)      : 1;
    localparam int GAP_W = (GAP_CYC > 1)    ? $clog2(GAP_CYC)    : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    // Registered state
    seg_state_e                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [DW_W-1:0]           r_dwell;
    logic [GAP_W-1:0]          r_gap;
    logic [3:0]                r_shadow [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0]   r_pending_data;
    logic                      r_pending;
    logic                      r_committed;
    logic                      r_frame_start;

    // Next-state and decode wires
    seg_state_e                w_state_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [IDX_W-1:0]          w_idx_inc;
    logic [DW_W-1:0]           w_dwell_nxt;
    logic [GAP_W-1:0]          w_gap_nxt;
    logic                      w_wrap;
    logic                      w_commit;
    logic                      w_accept;
    logic                      w_entry0;
    logic [3:0]                w_cur_digit;
    logic [6:0]                w_seg_dec;
    logic [NUM_DIGITS-1:0]     w_blank;
    logic                      w_lit;

    // Ready is simply "pending buffer empty": it drops the cycle after an
    // accept and returns the cycle after the pending data is committed.
    assign load_ready = ~r_pending;
    assign w_accept   = load_valid & load_ready;

    assign w_idx_inc  = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_gap_nxt   = r_gap;
        w_wrap      = 1'b0;

        if (!en) begin
            w_state_nxt = ST_DARK;
            w_idx_nxt   = '0;
            w_dwell_nxt = '0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                ST_DARK: begin
                    // Nothing meaningful to show until the first commit.
                    if (r_committed) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = '0;
                        w_dwell_nxt = '0;
                    end
                end

                ST_SCAN: begin
                    if (r_dwell == DW_LAST) begin
                        w_dwell_nxt = '0;
                        if (GAP_CYC == 0) begin
                            w_state_nxt = ST_SCAN;
                            w_idx_nxt   = w_idx_inc;
                            w_wrap      = (r_idx == IDX_LAST);
                        end else begin
                            w_state_nxt = ST_GAP;
                            w_gap_nxt   = '0;
                        end
                    end else begin
                        w_dwell_nxt = r_dwell + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = w_idx_inc;
                        w_gap_nxt   = '0;
                        w_wrap      = (r_idx == IDX_LAST);
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = ST_DARK;
                    w_idx_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_gap_nxt   = '0;
                end
            endcase
        end
    end

    // Pending data moves to the display either straight away while dark, or
    // at the wrap from the last digit back to digit 0 (frame boundary).
    assign w_commit = r_pending & ((r_state == ST_DARK) | w_wrap);

    // Any transition that lands on the digit-0 slot starts a frame; staying
    // in the digit-0 slot while dwelling does not.
    assign w_entry0 = (w_state_nxt == ST_SCAN) && (w_idx_nxt == '0)
                      && ((r_state != ST_SCAN) || w_wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_DARK;
            r_idx         <= '0;
            r_dwell       <= '0;
            r_gap         <= '0;
            r_pending     <= 1'b0;
            r_committed   <= 1'b0;
            r_frame_start <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= 4'hF;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_dwell       <= w_dwell_nxt;
            r_gap         <= w_gap_nxt;
            r_frame_start <= w_entry0;

            if (w_commit) begin
                r_committed <= 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_shadow[i] <= r_pending_data[4*i +: 4];
                end
            end

            // An accept in the same cycle as a commit refills the buffer,
            // so the accept takes priority over the clear.
            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Payload register: only written on accept, needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pending_data <= load_data;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // Walk down from the most significant digit; a digit is blanked while
    // it and everything above it are zero. Digit 0 is excluded.
    always_comb begin : lzb_blk
        logic v_zero_above;
        v_zero_above = 1'b1;
        w_blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_zero_above = v_zero_above && (r_shadow[i] == 4'd0);
            w_blank[i]   = v_zero_above;
        end
    end
`else
    assign w_blank = '0;
`endif

    // Single shared decoder, fed by the digit currently being scanned.
    assign w_cur_digit = r_shadow[r_idx];

    seg_bcd_decode u_decode (
        .i_bcd   (w_cur_digit),
        .o_seg_n (w_seg_dec)
    );

    assign w_lit = (r_state == ST_SCAN) && !w_blank[r_idx];

    always_comb begin
        an_n = '1;
        if (w_lit) begin
            an_n[r_idx] = 1'b0;
        end
    end

    assign seg_n       = w_lit ? w_seg_dec : SEG_BLANK;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL=4, GAP_CYC=2.
//   Frame = 24 cycles: per digit 4 lit cycles then 2 dark cycles.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] lzb_0005;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .DWELL      (4),
        .GAP_CYC    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Accept edge, commit edge (dark), then SCAN of digit 0 on the third edge.
    task automatic load_and_start(input logic [15:0] data);
        en         = 1'b1;
        load_valid = 1'b1;
        load_data  = data;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        if (an_n !== 4'hF) begin n_fail++; $display("FAIL reset_an_n got=%h exp=%h", an_n, 4'hF); end
        n_checks++;
        if (seg_n !== 7'h7F) begin n_fail++; $display("FAIL reset_seg_n got=%h exp=%h", seg_n, 7'h7F); end
        n_checks++;
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        n_checks++;
        en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (an_n !== 4'hF || seg_n !== 7'h7F || load_ready !== 1'b1 || frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL dark_hold cyc=%0d got an=%h seg=%h rdy=%b fs=%b exp an=f seg=7f rdy=1 fs=0",
                         k, an_n, seg_n, load_ready, frame_start);
            end
            n_checks++;
        end
    endtask

    task automatic test_scan();
        logic [15:0] dig;
        logic [1:0]  slot;
        logic        lit;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_fs;
        do_reset();
        en         = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1234;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL scan_ready_after_accept got=%b exp=0", load_ready); end
        n_checks++;
        step();
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL scan_ready_after_commit got=%b exp=1", load_ready); end
        n_checks++;
        if (an_n !== 4'hF) begin n_fail++; $display("FAIL scan_dark_at_commit got=%h exp=f", an_n); end
        n_checks++;
        step();
        dig = 16'h1234;
        for (int k = 0; k < 48; k++) begin
            slot    = 2'((k % 24) / 6);
            lit     = ((k % 6) < 4);
            exp_an  = 4'hF;
            if (lit) exp_an[slot] = 1'b0;
            exp_seg = lit ? seg_of(dig[4*slot +: 4]) : 7'h7F;
            exp_fs  = ((k % 24) == 0);
            if (an_n !== exp_an) begin n_fail++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", k, an_n, exp_an); end
            n_checks++;
            if (seg_n !== exp_seg) begin n_fail++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", k, seg_n, exp_seg); end
            n_checks++;
            if (frame_start !== exp_fs) begin n_fail++; $display("FAIL scan_fs cyc=%0d got=%b exp=%b", k, frame_start, exp_fs); end
            n_checks++;
            step();
        end
    endtask

    task automatic test_midframe_load();
        logic [15:0] dig;
        logic [3:0]  mask;
        logic [1:0]  slot;
        logic        lit;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_rdy;
        do_reset();
        load_and_start(16'h1234);
        for (int k = 0; k < 48; k++) begin
            dig     = (k < 24) ? 16'h1234 : 16'h0005;
            mask    = (k < 24) ? 4'b0000 : lzb_0005;
            slot    = 2'((k % 24) / 6);
            lit     = ((k % 6) < 4) && !mask[slot];
            exp_an  = 4'hF;
            if (lit) exp_an[slot] = 1'b0;
            exp_seg = lit ? seg_of(dig[4*slot +: 4]) : 7'h7F;
            exp_rdy = !((k >= 6) && (k < 24));
            if (an_n !== exp_an) begin n_fail++; $display("FAIL mid_an cyc=%0d got=%h exp=%h", k, an_n, exp_an); end
            n_checks++;
            if (seg_n !== exp_seg) begin n_fail++; $display("FAIL mid_seg cyc=%0d got=%h exp=%h", k, seg_n, exp_seg); end
            n_checks++;
            if (load_ready !== exp_rdy) begin n_fail++; $display("FAIL mid_ready cyc=%0d got=%b exp=%b", k, load_ready, exp_rdy); end
            n_checks++;
            if (k == 5) begin
                load_valid = 1'b1; load_data = 16'h0005;
            end else if (k == 10) begin
                load_valid = 1'b1; load_data = 16'h9999;
            end else if (k == 6 || k == 16) begin
                load_valid = 1'b0; load_data = '0;
            end
            step();
        end
    endtask

    task automatic test_hex_codes();
        logic [15:0] vecs [2];
        logic [15:0] dig;
        logic [1:0]  slot;
        logic        lit;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        vecs[0] = 16'hAB0F;
        vecs[1] = 16'h6789;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            dig = vecs[v];
            load_and_start(dig);
            for (int k = 0; k < 24; k++) begin
                slot    = 2'(k / 6);
                lit     = ((k % 6) < 4);
                exp_an  = 4'hF;
                if (lit) exp_an[slot] = 1'b0;
                exp_seg = lit ? seg_of(dig[4*slot +: 4]) : 7'h7F;
                if (an_n !== exp_an) begin n_fail++; $display("FAIL hex_an vec=%h cyc=%0d got=%h exp=%h", dig, k, an_n, exp_an); end
                n_checks++;
                if (seg_n !== exp_seg) begin n_fail++; $display("FAIL hex_seg vec=%h cyc=%0d got=%h exp=%h", dig, k, seg_n, exp_seg); end
                n_checks++;
                step();
            end
        end
    endtask

    task automatic test_enable();
        logic [15:0] dig;
        logic [1:0]  slot;
        logic        lit;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_fs;
        do_reset();
        load_and_start(16'h1234);
        for (int k = 0; k < 13; k++) step();
        if (an_n !== 4'b1011) begin n_fail++; $display("FAIL en_digit2_lit got=%h exp=b", an_n); end
        n_checks++;
        en = 1'b0;
        step();
        if (an_n !== 4'hF || seg_n !== 7'h7F || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL en_off_dark got an=%h seg=%h fs=%b exp an=f seg=7f fs=0", an_n, seg_n, frame_start);
        end
        n_checks++;
        load_valid = 1'b1;
        load_data  = 16'h4321;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL en_off_accept got=%b exp=0", load_ready); end
        n_checks++;
        step();
        if (load_ready !== 1'b1) begin n_fail++; $display("FAIL en_off_commit got=%b exp=1", load_ready); end
        n_checks++;
        step();
        step();
        if (an_n !== 4'hF || seg_n !== 7'h7F) begin
            n_fail++;
            $display("FAIL en_off_hold got an=%h seg=%h exp an=f seg=7f", an_n, seg_n);
        end
        n_checks++;
        en = 1'b1;
        step();
        dig = 16'h4321;
        for (int k = 0; k < 24; k++) begin
            slot    = 2'(k / 6);
            lit     = ((k % 6) < 4);
            exp_an  = 4'hF;
            if (lit) exp_an[slot] = 1'b0;
            exp_seg = lit ? seg_of(dig[4*slot +: 4]) : 7'h7F;
            exp_fs  = (k == 0);
            if (an_n !== exp_an) begin n_fail++; $display("FAIL en_resume_an cyc=%0d got=%h exp=%h", k, an_n, exp_an); end
            n_checks++;
            if (seg_n !== exp_seg) begin n_fail++; $display("FAIL en_resume_seg cyc=%0d got=%h exp=%h", k, seg_n, exp_seg); end
            n_checks++;
            if (frame_start !== exp_fs) begin n_fail++; $display("FAIL en_resume_fs cyc=%0d got=%b exp=%b", k, frame_start, exp_fs); end
            n_checks++;
            step();
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        load_and_start(16'h1234);
        for (int k = 0; k < 4; k++) step();
        if (an_n !== 4'hF) begin n_fail++; $display("FAIL rstmid_in_gap got=%h exp=f", an_n); end
        n_checks++;
        load_valid = 1'b1;
        load_data  = 16'h5678;
        step();
        if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending got=%b exp=0", load_ready); end
        n_checks++;
        rst = 1'b1;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        rst        = 1'b0;
        if (an_n !== 4'hF || seg_n !== 7'h7F || load_ready !== 1'b1 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_values got an=%h seg=%h rdy=%b fs=%b exp an=f seg=7f rdy=1 fs=0",
                     an_n, seg_n, load_ready, frame_start);
        end
        n_checks++;
        for (int k = 0; k < 10; k++) begin
            step();
            if (an_n !== 4'hF || seg_n !== 7'h7F || load_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_stays_dark cyc=%0d got an=%h seg=%h rdy=%b exp an=f seg=7f rdy=1",
                         k, an_n, seg_n, load_ready);
            end
            n_checks++;
        end
    endtask

    initial begin
`ifdef SEG_SCAN_LZB_EN
        lzb_0005 = 4'b1110;
`else
        lzb_0005 = 4'b0000;
`endif
        rst        = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_midframe_load();
        test_hex_codes();
        test_enable();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
